counter_updown_param: RTL and testbench

Parametrised synchronous up/down counter, successor to the fixed 8-bit up/down counter. Adds configurable width, modulus, step size, wrap/saturate mode, enable, synchronous clear, parallel load, and terminal-count and overflow flags. Serves as the general counting primitive for timers, address generators and event tallies.

---
 rtl/counter_updown_param.sv | 90 +++++++++
 tb/tb_counter_updown_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with modulus, step, wrap/saturate mode,
// synchronous clear/load, combinational terminal count and a registered boundary pulse.
module counter_updown_param #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP     = 1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             p_clk_in,
    input  logic             p_rst,
    input  logic             p_en,
    input  logic             p_dir,
    input  logic             p_clr,
    input  logic             p_load,
    input  logic [WIDTH-1:0] p_load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("counter_updown_param: WIDTH must be 2..32");
        end
        if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("counter_updown_param: MAX_VAL must be 1..2^WIDTH-1");
        end
        if (STEP < 1 || STEP > MAX_VAL) begin : g_bad_step
            $error("counter_updown_param: STEP must be 1..MAX_VAL");
        end
    endgenerate

    // One extra bit so count+STEP and count+modulus never truncate before the compare.
    localparam longint unsigned MOD_L  = MAX_VAL + 64'd1;
    localparam logic [WIDTH:0]   MAX_W  = MAX_VAL[WIDTH:0];
    localparam logic [WIDTH:0]   STEP_W = STEP[WIDTH:0];
    localparam logic [WIDTH:0]   MOD_W  = MOD_L[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_C  = MAX_VAL[WIDTH-1:0];

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   sum_up;
    logic             up_ok;
    logic             dn_ok;
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;

    assign cnt_ext = {1'b0, count};
    assign sum_up  = cnt_ext + STEP_W;
    assign up_ok   = (sum_up <= MAX_W);
    assign dn_ok   = (cnt_ext >= STEP_W);

    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        if (p_clr) begin
            count_nxt = '0;
        end else if (p_load) begin
            count_nxt = ({1'b0, p_load_val} > MAX_W) ? MAX_C : p_load_val;
        end else if (p_en) begin
            if (p_dir) begin
                if (up_ok) begin
                    count_nxt = WIDTH'(sum_up);
                end else begin
                    ovf_nxt   = 1'b1;
                    count_nxt = SATURATE ? MAX_C : WIDTH'(sum_up - MOD_W);
                end
            end else begin
                if (dn_ok) begin
                    count_nxt = WIDTH'(cnt_ext - STEP_W);
                end else begin
                    ovf_nxt   = 1'b1;
                    count_nxt = SATURATE ? '0 : WIDTH'(cnt_ext + MOD_W - STEP_W);
                end
            end
        end
    end

    always_ff @(posedge p_clk_in or negedge p_rst) begin
        if (!p_rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign tc = (p_dir & (count == MAX_C)) | (~p_dir & (count == '0));

endmodule

// File: tb/tb_counter_updown_param.sv
// Bench for counter_updown_param: three instances (default, modulo-10 step-3 wrap,
// modulo-10 step-3 saturate) share one stimulus stream; a reference model feeds a scoreboard.
module tb_counter_updown_param;

    logic             p_clk_in = 1'b0;
    logic             p_rst;
    logic             p_en;
    logic             p_dir;
    logic             p_clr;
    logic             p_load;
    logic [7:0]       p_load_val;
    logic [2:0][7:0]  cnt;
    logic [2:0]       tcs;
    logic [2:0]       ovfs;

    int total = 0;
    int bad   = 0;
    int mc[3];

    typedef struct packed {
        logic [2:0][31:0] c;
        logic [2:0]       o;
        logic [2:0]       t;
    } exp_t;

    exp_t sb[$];

    always #5 p_clk_in = ~p_clk_in;

    counter_updown_param u_def (
        .p_clk_in(p_clk_in), .p_rst(p_rst), .p_en(p_en), .p_dir(p_dir),
        .p_clr(p_clr), .p_load(p_load), .p_load_val(p_load_val),
        .count(cnt[0]), .tc(tcs[0]), .ovf(ovfs[0])
    );

    counter_updown_param #(.WIDTH(8), .MAX_VAL(9), .STEP(3), .SATURATE(1'b0)) u_wrap (
        .p_clk_in(p_clk_in), .p_rst(p_rst), .p_en(p_en), .p_dir(p_dir),
        .p_clr(p_clr), .p_load(p_load), .p_load_val(p_load_val),
        .count(cnt[1]), .tc(tcs[1]), .ovf(ovfs[1])
    );

    counter_updown_param #(.WIDTH(8), .MAX_VAL(9), .STEP(3), .SATURATE(1'b1)) u_sat (
        .p_clk_in(p_clk_in), .p_rst(p_rst), .p_en(p_en), .p_dir(p_dir),
        .p_clr(p_clr), .p_load(p_load), .p_load_val(p_load_val),
        .count(cnt[2]), .tc(tcs[2]), .ovf(ovfs[2])
    );

    function automatic int mxv(input int i);
        return (i == 0) ? 255 : 9;
    endfunction

    function automatic int stv(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    // Drive one cycle of controls, predict every instance, then compare just after the edge.
    task automatic step(input bit en, input bit dir, input bit clr, input bit ld, input int lv);
        exp_t e;
        exp_t got;
        p_en = en; p_dir = dir; p_clr = clr; p_load = ld; p_load_val = 8'(lv);
        e = '0;
        for (int i = 0; i < 3; i++) begin
            int  c;
            bit  o;
            c = mc[i];
            o = 1'b0;
            if (clr)      c = 0;
            else if (ld)  c = (lv > mxv(i)) ? mxv(i) : lv;
            else if (en) begin
                if (dir) begin
                    if (c + stv(i) <= mxv(i)) c = c + stv(i);
                    else begin o = 1'b1; c = (i == 2) ? mxv(i) : c + stv(i) - mxv(i) - 1; end
                end else begin
                    if (c >= stv(i)) c = c - stv(i);
                    else begin o = 1'b1; c = (i == 2) ? 0 : c + mxv(i) + 1 - stv(i); end
                end
            end
            mc[i]  = c;
            e.c[i] = 32'(c);
            e.o[i] = o;
            e.t[i] = dir ? (c == mxv(i)) : (c == 0);
        end
        sb.push_back(e);
        @(posedge p_clk_in);
        #1;
        got = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            chk("count", i, 32'(cnt[i]), got.c[i]);
            chk("ovf",   i, 32'(ovfs[i]), 32'(got.o[i]));
            chk("tc",    i, 32'(tcs[i]),  32'(got.t[i]));
        end
    endtask

    initial begin
        p_rst = 1'b0; p_en = 1'b0; p_dir = 1'b0; p_clr = 1'b0; p_load = 1'b0; p_load_val = '0;
        for (int i = 0; i < 3; i++) mc[i] = 0;

        // reset held for three edges
        repeat (3) @(posedge p_clk_in);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_count", i, 32'(cnt[i]), 32'd0);
            chk("rst_ovf",   i, 32'(ovfs[i]), 32'd0);
            chk("rst_tc",    i, 32'(tcs[i]),  32'd1);
        end
        p_rst = 1'b1;

        // full up wrap on the default instance
        for (int k = 1; k <= 256; k++) begin
            step(1, 1, 0, 0, 0);
            chk("upwrap", 0, 32'(cnt[0]), 32'(k % 256));
            if (k == 255) chk("tc255", 0, 32'(tcs[0]), 32'd1);
        end
        chk("upwrap_ovf", 0, 32'(ovfs[0]), 32'd1);

        // down wrap from 0
        step(1, 0, 0, 0, 0);
        chk("dnwrap", 0, 32'(cnt[0]), 32'd255);
        chk("dnwrap_ovf", 0, 32'(ovfs[0]), 32'd1);
        step(1, 0, 0, 0, 0);
        chk("dnwrap2", 0, 32'(cnt[0]), 32'd254);
        chk("dnwrap2_ovf", 0, 32'(ovfs[0]), 32'd0);

        // modulus 10, step 3, wrap
        step(0, 1, 1, 0, 0);
        begin
            int up_seq[5] = '{3, 6, 9, 2, 5};
            int dn_seq[3] = '{2, 9, 6};
            for (int k = 0; k < 5; k++) begin
                step(1, 1, 0, 0, 0);
                chk("mod_up", 1, 32'(cnt[1]), 32'(up_seq[k]));
                chk("mod_up_ovf", 1, 32'(ovfs[1]), (k == 3) ? 32'd1 : 32'd0);
            end
            for (int k = 0; k < 3; k++) begin
                step(1, 0, 0, 0, 0);
                chk("mod_dn", 1, 32'(cnt[1]), 32'(dn_seq[k]));
                chk("mod_dn_ovf", 1, 32'(ovfs[1]), (k == 1) ? 32'd1 : 32'd0);
            end
        end

        // saturate at both limits
        step(0, 1, 0, 1, 8);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0, 0);
            chk("sat_up", 2, 32'(cnt[2]), 32'd9);
            chk("sat_up_ovf", 2, 32'(ovfs[2]), 32'd1);
        end
        step(0, 0, 0, 1, 1);
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 0, 0, 0);
            chk("sat_dn", 2, 32'(cnt[2]), 32'd0);
            chk("sat_dn_ovf", 2, 32'(ovfs[2]), 32'd1);
        end

        // clear beats load beats enable; load clamps to MAX_VAL
        step(1, 1, 1, 1, 50);
        for (int i = 0; i < 3; i++) chk("prio_clr", i, 32'(cnt[i]), 32'd0);
        step(0, 1, 0, 1, 200);
        chk("load", 0, 32'(cnt[0]), 32'd200);
        chk("load_clamp", 1, 32'(cnt[1]), 32'd9);
        chk("load_clamp", 2, 32'(cnt[2]), 32'd9);
        repeat (5) begin
            step(0, 1, 0, 0, 0);
            chk("hold", 0, 32'(cnt[0]), 32'd200);
        end

        // asynchronous reset between edges
        step(0, 1, 0, 1, 99);
        step(1, 1, 0, 0, 0);
        chk("pre_rst", 0, 32'(cnt[0]), 32'd100);
        #3;
        p_rst = 1'b0;
        p_load = 1'b1; p_load_val = 8'd77;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("async_count", i, 32'(cnt[i]), 32'd0);
            chk("async_ovf",   i, 32'(ovfs[i]), 32'd0);
            mc[i] = 0;
        end
        @(posedge p_clk_in);
        #1;
        chk("rst_hold", 0, 32'(cnt[0]), 32'd0);
        p_rst = 1'b1;
        step(1, 1, 0, 0, 0);
        chk("post_rst", 0, 32'(cnt[0]), 32'd1);

        chk("sb_empty", 0, 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
